fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the multicycle MIPS core, directly upstream of the control-unit FSM. It owns the PC and IR registers and fetches from memory over a valid/ready handshake with variable latency. It supplies Op/Funct to the control unit and asserts `stall` to hold that FSM in its fetch state until the instruction word arrives. It applies the control unit's PC-update strobes: increment, branch and jump.

## Interface
- `WIDTH`, 32: data/address width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PC_Write`  in  1  unconditional PC update.
- `Branch`  in  1  conditional PC update, qualified by `Zero`.
- `Zero`  in  1  ALU zero flag.
- `PC_Src`  in  1  0: `alu_result`, 1: `alu_out` (registered branch target).
- `PC_J`  in  1  0: jump target, 1: `PC_Src` path.
- `IR_Write`  in  1  fetch request; held high by control unit in fetch state.
- `alu_result`  in  WIDTH  combinational ALU output (PC+4 during fetch).
- `alu_out`  in  WIDTH  registered ALU output.
- `mem_req_valid`  out  1  fetch request valid.
- `mem_req_addr`  out  WIDTH  fetch byte address (= `pc`).
- `mem_req_ready`  in  1  memory accepts request.
- `mem_rsp_valid`  in  1  instruction word valid.
- `mem_rsp_data`  in  WIDTH  instruction word.
- `pc`  out  WIDTH  current PC register.
- `instr`  out  WIDTH  instruction register.
- `Op`  out  6  `instr[31:26]`.
- `Funct`  out  6  `instr[5:0]`.
- `stall`  out  1  control unit must not advance state.
- `fetch_fault`  out  1  sticky misaligned-PC fault.
- `instr_count`  out  32  retired-fetch counter.

## Operation
- States: IDLE, REQ, WAIT, FAULT.
- **IDLE**
  - `IR_Write`=1 and `pc[1:0]`=0: `mem_req_valid`=1 combinationally. Next state is WAIT if `mem_req_ready`=1, otherwise REQ.
  - `IR_Write`=1 and `pc[1:0]`!=0: no request; go to FAULT.
- **REQ**
  - `mem_req_valid`=1 and `mem_req_addr`=`pc`, both held stable until `mem_req_ready`=1; then go to WAIT.
- **WAIT**
  - On `mem_rsp_valid`=1: `instr` <= `mem_rsp_data`, `instr_count` += 1 (wraps at 2^32), go to IDLE.
- **FAULT**
  - Terminal until `rst`. `fetch_fault`=1, `stall`=1, no requests issued.
- `stall` = `IR_Write` & ~(state==WAIT & `mem_rsp_valid`) & `fetch_fault`-independent, ORed with state==FAULT.
- PC enable = (`PC_Write` | (`Branch` & `Zero`)) & ~`stall`.
- PC next value:
  - `PC_J`=0: {`pc[31:28]`, `instr[25:0]`, 2'b00}.
  - `PC_J`=1 and `PC_Src`=0: `alu_result`.
  - `PC_J`=1 and `PC_Src`=1: `alu_out`.
- Jump target uses the current IR and the already-incremented PC.
- `mem_rsp_valid` outside WAIT is ignored: no IR write, no count.
- Reset mid-fetch returns to IDLE. A response still in flight for the aborted request is dropped. Memory must not present it as a new response after the next accept.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instr`=0 (nop), `instr_count`=0.
  - State IDLE, so `fetch_fault`=0 and `mem_req_valid`=0.
  - `stall` follows `IR_Write` combinationally.
- Minimum fetch: request accepted in the first `IR_Write` cycle, response in the next cycle. The control unit spends 2 cycles in fetch.
- Each extra ready-wait or response-wait cycle adds one cycle.
- IR capture and PC+4 update occur on the same edge: the edge ending the cycle where `mem_rsp_valid`=1 in WAIT.
- At most one request is outstanding. Memory responds no earlier than the cycle after acceptance.
- PC/IR updates outside fetch (branch, jump) take effect on the next edge with no stall.

## Structure
- Shared `mips_defs` package/header:
  - `WIDTH`
  - opcode constants (`OP_RTYPE`=6'h00, `OP_J`=6'h02, `OP_BEQ`=6'h04, `OP_ADDI`=6'h08, `OP_ORI`=6'h0d)
  - `FUNCT_ADD`=6'h20
  - fetch state encodings
- Sub-module `pc_next_sel`: combinational PC mux and enable. The FSM, registers and counter stay in `fetch_unit`.

## Test plan
- **Reset then fetch:** `rst`=1 then 0, `IR_Write`=1, ready=1, response 0x2008_0005 one cycle later. Required: `stall`=1 for one cycle, then `Op`=6'h08, `pc`=4, `instr_count`=1.
- **Backpressure:** `mem_req_ready` low for 3 cycles, response 2 cycles after accept. Required: `mem_req_addr` stable; `stall` high for 5 cycles total; PC unchanged until the capture edge.
- **Branch:** `Branch`=1, `Zero`=1, `PC_Src`=1, `PC_J`=1, `alu_out`=0x40. Required: `pc`=0x40 next cycle. Same with `Zero`=0: `pc` unchanged.
- **Jump:** `instr`=0x0800_0010, `pc`=0x0000_0008, `PC_Write`=1, `PC_J`=0. Required: `pc`=0x0000_0040.
- **Misaligned PC:** jump or branch leaves `pc`=0x42, then `IR_Write`=1. Required: no request issued; `fetch_fault`=1 and `stall`=1 until `rst`.
- **Reset mid-WAIT:** `rst` pulsed while a response is pending; stray `mem_rsp_valid` arrives in IDLE. Required: `instr`=0, `instr_count`=0, `pc`=`RESET_PC`.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS core definitions: datapath width, opcode/funct constants and
// fetch-stage state encodings.
package mips_defs;

  localparam int WIDTH = 32;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] FUNCT_ADD = 6'h20;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_WAIT  = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// PC next-value mux and write enable for the fetch stage.
// Purely combinational; the PC register itself lives in fetch_unit.
module pc_next_sel
  import mips_defs::*;
#(
  parameter int W = WIDTH
) (
  input  logic [3:0]   pc_hi,
  input  logic [25:0]  jidx,
  input  logic [W-1:0] alu_result,
  input  logic [W-1:0] alu_out,
  input  logic         PC_J,
  input  logic         PC_Src,
  input  logic         PC_Write,
  input  logic         Branch,
  input  logic         Zero,
  input  logic         stall,
  output logic         pc_en,
  output logic [W-1:0] pc_next
);

  always_comb begin
    pc_en = (PC_Write | (Branch & Zero)) & ~stall;
    if (!PC_J)
      pc_next = {pc_hi, jidx, 2'b00};
    else if (PC_Src)
      pc_next = alu_out;
    else
      pc_next = alu_result;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC/IR, fetches over a valid/ready memory port
// with variable latency and stalls the control FSM until the word arrives.
module fetch_unit
  import mips_defs::*;
#(
  parameter int          WIDTH    = mips_defs::WIDTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PC_Write,
  input  logic             Branch,
  input  logic             Zero,
  input  logic             PC_Src,
  input  logic             PC_J,
  input  logic             IR_Write,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_out,
  output logic             mem_req_valid,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rsp_data,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       Op,
  output logic [5:0]       Funct,
  output logic             stall,
  output logic             fetch_fault,
  output logic [31:0]      instr_count
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [31:0]      count_q, count_d;

  logic             pc_en;
  logic [WIDTH-1:0] pc_next;
  logic             aligned;
  logic             rsp_take;

  assign aligned  = (pc_q[1:0] == 2'b00);
  assign rsp_take = (state_q == FS_WAIT) & mem_rsp_valid;

  assign stall         = (IR_Write & ~rsp_take) | (state_q == FS_FAULT);
  assign fetch_fault   = (state_q == FS_FAULT);
  assign mem_req_valid = ((state_q == FS_IDLE) & IR_Write & aligned) |
                         (state_q == FS_REQ);
  assign mem_req_addr  = pc_q;

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign Op          = instr_q[31:26];
  assign Funct       = instr_q[5:0];
  assign instr_count = count_q;

  pc_next_sel #(.W(WIDTH)) u_pc_next_sel (
    .pc_hi      (pc_q[WIDTH-1:WIDTH-4]),
    .jidx       (instr_q[25:0]),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .PC_J       (PC_J),
    .PC_Src     (PC_Src),
    .PC_Write   (PC_Write),
    .Branch     (Branch),
    .Zero       (Zero),
    .stall      (stall),
    .pc_en      (pc_en),
    .pc_next    (pc_next)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    count_d = count_q;
    pc_d    = pc_en ? pc_next : pc_q;
    unique case (state_q)
      FS_IDLE: begin
        if (IR_Write) begin
          if (!aligned)          state_d = FS_FAULT;
          else if (mem_req_ready) state_d = FS_WAIT;
          else                    state_d = FS_REQ;
        end
      end
      FS_REQ:  if (mem_req_ready) state_d = FS_WAIT;
      FS_WAIT: begin
        if (mem_rsp_valid) begin
          instr_d = mem_rsp_data;
          count_d = count_q + 32'd1;
          state_d = FS_IDLE;
        end
      end
      FS_FAULT: state_d = FS_FAULT;
      default:  state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC[WIDTH-1:0];
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scripted control-unit/memory behaviour,
// fetched words go through a scoreboard queue and are compared at IR capture.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_Write, Branch, Zero, PC_Src, PC_J, IR_Write;
  logic [31:0] alu_result, alu_out;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_rsp_data;
  logic [31:0] pc, instr, instr_count;
  logic [5:0]  Op, Funct;
  logic        stall, fetch_fault;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mpc;
  logic [31:0] mcnt;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .PC_Write(PC_Write), .Branch(Branch), .Zero(Zero), .PC_Src(PC_Src),
    .PC_J(PC_J), .IR_Write(IR_Write),
    .alu_result(alu_result), .alu_out(alu_out),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .pc(pc), .instr(instr), .Op(Op), .Funct(Funct),
    .stall(stall), .fetch_fault(fetch_fault), .instr_count(instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    PC_Write = 0; Branch = 0; Zero = 0; PC_Src = 0; PC_J = 0; IR_Write = 0;
    alu_result = '0; alu_out = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // rw: cycles with ready low; sw: response-wait cycles after accept
  task automatic fetch(input logic [31:0] data, input int rw, input int sw);
    int st = 0;
    logic [31:0] e;
    step();
    IR_Write = 1; PC_Write = 1; PC_J = 1; PC_Src = 0; alu_result = mpc + 4;
    for (int i = 0; i < rw; i++) begin
      mem_req_ready = 0;
      @(negedge clk);
      chk("req_valid_bp", {31'd0, mem_req_valid}, 32'd1);
      chk("req_addr_bp", mem_req_addr, mpc);
      chk("pc_hold_bp", pc, mpc);
      if (stall) st++;
      step();
    end
    mem_req_ready = 1;
    @(negedge clk);
    chk("req_valid_acc", {31'd0, mem_req_valid}, 32'd1);
    chk("req_addr_acc", mem_req_addr, mpc);
    if (stall) st++;
    exp_q.push_back(data);
    step();
    mem_req_ready = 0;
    for (int i = 0; i < sw; i++) begin
      @(negedge clk);
      chk("req_valid_wait", {31'd0, mem_req_valid}, 32'd0);
      chk("pc_hold_wait", pc, mpc);
      if (stall) st++;
      step();
    end
    mem_rsp_valid = 1; mem_rsp_data = data;
    @(negedge clk);
    chk("stall_rsp", {31'd0, stall}, 32'd0);
    chk("pc_pre_cap", pc, mpc);
    step();
    clr_in();
    mpc  = mpc + 4;
    mcnt = mcnt + 1;
    @(negedge clk);
    if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      chk("instr", instr, e);
      chk("op", {26'd0, Op}, {26'd0, e[31:26]});
      chk("funct", {26'd0, Funct}, {26'd0, e[5:0]});
    end
    chk("pc_cap", pc, mpc);
    chk("count", instr_count, mcnt);
    chk("stall_cycles", st, rw + 1 + sw);
  endtask

  task automatic br(input logic [31:0] tgt, input logic z);
    step();
    Branch = 1; Zero = z; PC_Src = 1; PC_J = 1; alu_out = tgt;
    step();
    clr_in();
    if (z) mpc = tgt;
    @(negedge clk);
    chk(z ? "branch_taken" : "branch_not_taken", pc, mpc);
  endtask

  task automatic do_reset();
    step();
    clr_in(); rst = 1;
    step(); step();
    rst = 0;
    mpc = 32'h0; mcnt = 32'h0;
  endtask

  initial begin
    clr_in();
    rst = 1;
    mpc = 0; mcnt = 0;
    do_reset();

    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_count", instr_count, 32'h0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // minimum-latency fetch
    fetch(32'h2008_0005, 0, 0);
    chk("t1_op", {26'd0, Op}, 32'h08);
    chk("t1_pc", pc, 32'h4);
    chk("t1_count", instr_count, 32'd1);

    // stray response in IDLE is ignored
    step();
    mem_rsp_valid = 1; mem_rsp_data = 32'hdead_beef;
    step();
    clr_in();
    @(negedge clk);
    chk("stray_instr", instr, 32'h2008_0005);
    chk("stray_count", instr_count, 32'd1);

    // backpressure: 3 ready-low cycles, response 2 cycles after accept
    fetch(32'h3421_00ff, 3, 1);
    chk("bp_pc", pc, 32'h8);

    br(32'h40, 1'b1);
    br(32'h80, 1'b0);

    // jump: IR = j 0x10 fetched from pc 4, so pc becomes 8 before the jump
    br(32'h4, 1'b1);
    fetch(32'h0800_0010, 0, 0);
    chk("j_pre_pc", pc, 32'h8);
    step();
    PC_Write = 1; PC_J = 0;
    step();
    clr_in();
    @(negedge clk);
    chk("jump_pc", pc, 32'h40);

    // reset while WAIT is pending, then stray response arrives in IDLE
    step();
    IR_Write = 1; mem_req_ready = 1;
    @(negedge clk);
    chk("mw_req_valid", {31'd0, mem_req_valid}, 32'd1);
    step();
    clr_in(); IR_Write = 1; rst = 1;
    step();
    clr_in(); rst = 0;
    mpc = 0; mcnt = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'h1234_5678;
    step();
    clr_in();
    @(negedge clk);
    chk("mw_instr", instr, 32'h0);
    chk("mw_count", instr_count, 32'h0);
    chk("mw_pc", pc, 32'h0);

    // misaligned PC
    br(32'h42, 1'b1);
    step();
    IR_Write = 1; PC_Write = 1; PC_J = 1; alu_result = 32'h46; mem_req_ready = 1;
    @(negedge clk);
    chk("mis_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i > 0) IR_Write = 0;
      @(negedge clk);
      chk("fault_flag", {31'd0, fetch_fault}, 32'd1);
      chk("fault_stall", {31'd0, stall}, 32'd1);
      chk("fault_req", {31'd0, mem_req_valid}, 32'd0);
      chk("fault_pc", pc, 32'h42);
    end
    do_reset();
    @(negedge clk);
    chk("fault_cleared", {31'd0, fetch_fault}, 32'd0);
    chk("fault_rst_pc", pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
